// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : RV32I decode stage with operand bypass, pending-write
//               scoreboard hazard detection and a single output register.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic [31:0]        instr_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    output logic [4:0]         rf_rs1_o,
    output logic [4:0]         rf_rs2_o,
    input  logic [BITSIZE-1:0] rf_data_rs1_i,
    input  logic [BITSIZE-1:0] rf_data_rs2_i,
    input  logic               wb_valid_i,
    input  logic [4:0]         wb_rd_i,
    input  logic [BITSIZE-1:0] wb_data_i,
    input  logic               flush_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [BITSIZE-1:0] ex_rs1_data_o,
    output logic [BITSIZE-1:0] ex_rs2_data_o,
    output logic [BITSIZE-1:0] ex_imm_o,
    output logic [4:0]         ex_rd_o,
    output logic [6:0]         ex_opcode_o,
    output logic [2:0]         ex_funct3_o,
    output logic [6:0]         ex_funct7_o
);

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    logic [6:0]         w_opcode;
    logic [4:0]         w_rs1;
    logic [4:0]         w_rs2;
    logic [4:0]         w_rd;
    logic               w_rs1_used;
    logic               w_rs2_used;
    logic               w_rd_wr;
    logic [31:0]        w_imm32;
    logic [BITSIZE-1:0] w_imm;
    logic [BITSIZE-1:0] w_rs1_data;
    logic [BITSIZE-1:0] w_rs2_data;
    logic               w_rs1_hazard;
    logic               w_rs2_hazard;
    logic               w_hazard;
    logic               w_issue;
    logic               w_accept;
    logic [31:0]        w_sb_set;
    logic [31:0]        w_sb_clr;

    logic               r_ex_valid;
    logic               r_ex_rd_wr;
    logic [BITSIZE-1:0] r_ex_rs1_data;
    logic [BITSIZE-1:0] r_ex_rs2_data;
    logic [BITSIZE-1:0] r_ex_imm;
    logic [4:0]         r_ex_rd;
    logic [6:0]         r_ex_opcode;
    logic [2:0]         r_ex_funct3;
    logic [6:0]         r_ex_funct7;
    logic [31:0]        r_scoreboard;

    assign w_opcode = instr_i[6:0];
    assign w_rd     = instr_i[11:7];
    assign w_rs1    = instr_i[19:15];
    assign w_rs2    = instr_i[24:20];
    assign rf_rs1_o = w_rs1;
    assign rf_rs2_o = w_rs2;

    assign w_rs1_used = !((w_opcode == c_OPC_LUI) || (w_opcode == c_OPC_AUIPC) ||
                          (w_opcode == c_OPC_JAL));
    assign w_rs2_used = (w_opcode == c_OPC_OP) || (w_opcode == c_OPC_STORE) ||
                        (w_opcode == c_OPC_BRANCH);
    assign w_rd_wr    = !((w_opcode == c_OPC_STORE) || (w_opcode == c_OPC_BRANCH)) &&
                        (w_rd != 5'd0);

    always_comb begin
        w_imm32 = 32'd0;
        case (w_opcode)
            c_OPC_JALR, c_OPC_LOAD, c_OPC_OPIMM:
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            c_OPC_STORE:
                w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            c_OPC_BRANCH:
                w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
            c_OPC_LUI, c_OPC_AUIPC:
                w_imm32 = {instr_i[31:12], 12'd0};
            c_OPC_JAL:
                w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            default:
                w_imm32 = 32'd0;
        endcase
    end

    generate
        if (BITSIZE > 32) begin : g_imm_wide
            assign w_imm = {{(BITSIZE-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_narrow
            assign w_imm = w_imm32[BITSIZE-1:0];
        end
    endgenerate

    // x0 wins over bypass, bypass wins over the (non write-through) register file
    always_comb begin
        w_rs1_data = rf_data_rs1_i;
        if (w_rs1 == 5'd0)
            w_rs1_data = '0;
        else if (wb_valid_i && (wb_rd_i == w_rs1))
            w_rs1_data = wb_data_i;

        w_rs2_data = rf_data_rs2_i;
        if (w_rs2 == 5'd0)
            w_rs2_data = '0;
        else if (wb_valid_i && (wb_rd_i == w_rs2))
            w_rs2_data = wb_data_i;
    end

    // The held writer is a hazard whether or not it issues: issuing makes it pending
    assign w_rs1_hazard = w_rs1_used &&
        ((r_scoreboard[w_rs1] && !(wb_valid_i && (wb_rd_i == w_rs1))) ||
         (r_ex_valid && r_ex_rd_wr && (r_ex_rd == w_rs1)));
    assign w_rs2_hazard = w_rs2_used &&
        ((r_scoreboard[w_rs2] && !(wb_valid_i && (wb_rd_i == w_rs2))) ||
         (r_ex_valid && r_ex_rd_wr && (r_ex_rd == w_rs2)));
    assign w_hazard = w_rs1_hazard || w_rs2_hazard;

    assign instr_ready_o = rstn_i && !w_hazard && (!r_ex_valid || ex_ready_i) && !flush_i;
    assign w_accept      = instr_valid_i && instr_ready_o;
    assign w_issue       = r_ex_valid && ex_ready_i && !flush_i;

    assign w_sb_set = (w_issue && r_ex_rd_wr) ? (32'h1 << r_ex_rd) : 32'h0;
    assign w_sb_clr = wb_valid_i ? (32'h1 << wb_rd_i) : 32'h0;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_scoreboard <= 32'h0;
        end else begin
            r_scoreboard <= ((r_scoreboard & ~w_sb_clr) | w_sb_set) & ~32'h1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ex_valid    <= 1'b0;
            r_ex_rd_wr    <= 1'b0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rd       <= 5'd0;
            r_ex_opcode   <= 7'd0;
            r_ex_funct3   <= 3'd0;
            r_ex_funct7   <= 7'd0;
        end else if (flush_i) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid    <= 1'b1;
            r_ex_rd_wr    <= w_rd_wr;
            r_ex_rs1_data <= w_rs1_data;
            r_ex_rs2_data <= w_rs2_data;
            r_ex_imm      <= w_imm;
            r_ex_rd       <= w_rd;
            r_ex_opcode   <= w_opcode;
            r_ex_funct3   <= instr_i[14:12];
            r_ex_funct7   <= instr_i[31:25];
        end else if (ex_ready_i) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid_o    = r_ex_valid;
    assign ex_rs1_data_o = r_ex_rs1_data;
    assign ex_rs2_data_o = r_ex_rs2_data;
    assign ex_imm_o      = r_ex_imm;
    assign ex_rd_o       = r_ex_rd;
    assign ex_opcode_o   = r_ex_opcode;
    assign ex_funct3_o   = r_ex_funct3;
    assign ex_funct7_o   = r_ex_funct7;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Directed self-checking bench for id_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk;
    logic        rstn_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [4:0]  rf_rs1_o;
    logic [4:0]  rf_rs2_o;
    logic [31:0] rf_data_rs1_i;
    logic [31:0] rf_data_rs2_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] ex_rs1_data_o;
    logic [31:0] ex_rs2_data_o;
    logic [31:0] ex_imm_o;
    logic [4:0]  ex_rd_o;
    logic [6:0]  ex_opcode_o;
    logic [2:0]  ex_funct3_o;
    logic [6:0]  ex_funct7_o;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage #(.BITSIZE(32)) dut (
        .clk           (clk),
        .rstn_i        (rstn_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .rf_rs1_o      (rf_rs1_o),
        .rf_rs2_o      (rf_rs2_o),
        .rf_data_rs1_i (rf_data_rs1_i),
        .rf_data_rs2_i (rf_data_rs2_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .flush_i       (flush_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .ex_rs1_data_o (ex_rs1_data_o),
        .ex_rs2_data_o (ex_rs2_data_o),
        .ex_imm_o      (ex_imm_o),
        .ex_rd_o       (ex_rd_o),
        .ex_opcode_o   (ex_opcode_o),
        .ex_funct3_o   (ex_funct3_o),
        .ex_funct7_o   (ex_funct7_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: unwritten entries read 0x1000+index, no write-through
    logic [31:0] rf [32];
    logic [31:0] wr_mask = 32'h0;
    always @(posedge clk) begin
        if (wb_valid_i && (wb_rd_i != 5'd0)) begin
            rf[wb_rd_i]      <= wb_data_i;
            wr_mask[wb_rd_i] <= 1'b1;
        end
    end
    assign rf_data_rs1_i = wr_mask[rf_rs1_o] ? rf[rf_rs1_o] : (32'h1000 + {27'd0, rf_rs1_o});
    assign rf_data_rs2_i = wr_mask[rf_rs2_o] ? rf[rf_rs2_o] : (32'h1000 + {27'd0, rf_rs2_o});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn_i        = 1'b0;
        instr_i       = 32'h00700293;
        instr_valid_i = 1'b1;
        wb_valid_i    = 1'b0;
        wb_rd_i       = 5'd0;
        wb_data_i     = 32'h0;
        flush_i       = 1'b0;
        ex_ready_i    = 1'b1;
        #3;
        chk("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, instr_ready_o}, 32'd0);
        chk("rst_imm", ex_imm_o, 32'd0);
        chk("rst_sb", dut.r_scoreboard, 32'd0);
        next_edge();
        next_edge();
        chk("rst_no_accept", {31'd0, ex_valid_o}, 32'd0);

        // ADDI x5,x0,7
        rstn_i = 1'b1;
        #2;
        chk("addi_ready", {31'd0, instr_ready_o}, 32'd1);
        chk("addi_rs1_addr", {27'd0, rf_rs1_o}, 32'd0);
        next_edge();
        chk("addi_ex_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("addi_rd", {27'd0, ex_rd_o}, 32'd5);
        chk("addi_imm", ex_imm_o, 32'd7);
        chk("addi_rs1", ex_rs1_data_o, 32'd0);
        chk("addi_opcode", {25'd0, ex_opcode_o}, 32'h13);
        instr_valid_i = 1'b0;
        next_edge();
        chk("addi_drain", {31'd0, ex_valid_o}, 32'd0);
        chk("addi_sb", dut.r_scoreboard, 32'h20);

        // ADD x6,x5,x5 stalls on pending x5 until write-back bypasses it
        instr_i       = 32'h00528333;
        instr_valid_i = 1'b1;
        #2;
        chk("add_stall0", {31'd0, instr_ready_o}, 32'd0);
        next_edge();
        chk("add_stall1", {31'd0, instr_ready_o}, 32'd0);
        chk("add_no_issue", {31'd0, ex_valid_o}, 32'd0);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd5;
        wb_data_i  = 32'h1234;
        #2;
        chk("add_wb_ready", {31'd0, instr_ready_o}, 32'd1);
        next_edge();
        wb_valid_i = 1'b0;
        chk("add_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("add_rs1_bypass", ex_rs1_data_o, 32'h1234);
        chk("add_rs2_bypass", ex_rs2_data_o, 32'h1234);
        chk("add_rd", {27'd0, ex_rd_o}, 32'd6);
        chk("add_sb_clear", dut.r_scoreboard, 32'h0);

        // Back-pressure for 3 cycles, then issue and accept in one cycle
        ex_ready_i = 1'b0;
        instr_i    = 32'h00300393;
        #2;
        chk("bp_ready", {31'd0, instr_ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_edge();
            chk("bp_valid", {31'd0, ex_valid_o}, 32'd1);
            chk("bp_rd", {27'd0, ex_rd_o}, 32'd6);
            chk("bp_rs1", ex_rs1_data_o, 32'h1234);
            chk("bp_ready_hold", {31'd0, instr_ready_o}, 32'd0);
        end
        ex_ready_i = 1'b1;
        #2;
        chk("bp_release_ready", {31'd0, instr_ready_o}, 32'd1);
        next_edge();
        chk("bp_next_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("bp_next_rd", {27'd0, ex_rd_o}, 32'd7);
        chk("bp_next_imm", ex_imm_o, 32'd3);
        chk("bp_sb", dut.r_scoreboard, 32'h40);

        // Flush the held x7 writer
        instr_valid_i = 1'b0;
        flush_i       = 1'b1;
        #2;
        chk("flush_ready", {31'd0, instr_ready_o}, 32'd0);
        next_edge();
        flush_i = 1'b0;
        chk("flush_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("flush_sb", dut.r_scoreboard, 32'h40);
        instr_i       = 32'h00138413;
        instr_valid_i = 1'b1;
        #2;
        chk("flush_reader_ready", {31'd0, instr_ready_o}, 32'd1);
        next_edge();
        chk("flush_reader_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("flush_reader_rs1", ex_rs1_data_o, 32'h1007);

        // Set and clear of x9 in one cycle: set wins; BEQ immediate
        instr_i = 32'h00100493;
        next_edge();
        chk("x9_accept_rd", {27'd0, ex_rd_o}, 32'd9);
        instr_i    = 32'hFE000EE3;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd9;
        wb_data_i  = 32'h55;
        #2;
        chk("beq_ready", {31'd0, instr_ready_o}, 32'd1);
        next_edge();
        wb_valid_i = 1'b0;
        chk("sb_set_wins", dut.r_scoreboard, 32'h340);
        chk("beq_imm", ex_imm_o, 32'hFFFFFFFC);
        chk("beq_opcode", {25'd0, ex_opcode_o}, 32'h63);

        // Asynchronous reset while holding a stalled instruction
        ex_ready_i    = 1'b0;
        instr_valid_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("arst_sb", dut.r_scoreboard, 32'h0);
        chk("arst_imm", ex_imm_o, 32'd0);
        chk("arst_ready", {31'd0, instr_ready_o}, 32'd0);
        next_edge();
        rstn_i        = 1'b1;
        ex_ready_i    = 1'b1;
        instr_i       = 32'h00528333;
        instr_valid_i = 1'b1;
        #2;
        chk("post_rst_ready", {31'd0, instr_ready_o}, 32'd1);
        next_edge();
        chk("post_rst_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("post_rst_rs1", ex_rs1_data_o, 32'h1234);
        chk("post_rst_rs2", ex_rs2_data_o, 32'h1234);

        // LUI x10,0x80000
        instr_i = 32'h80000537;
        #2;
        chk("lui_ready", {31'd0, instr_ready_o}, 32'd1);
        next_edge();
        chk("lui_imm", ex_imm_o, 32'h80000000);
        chk("lui_rd", {27'd0, ex_rd_o}, 32'd10);
        chk("lui_sb", dut.r_scoreboard, 32'h40);
        instr_valid_i = 1'b0;
        next_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: BITSIZE, 32, datapath width of operands, immediates and write-back data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-004 instr_i  input  32  RV32I instruction word from fetch.
REQ-005 instr_valid_i / instr_ready_o  input / output  1 / 1  fetch-side valid/ready handshake.
REQ-006 rf_rs1_o, rf_rs2_o  output  5 each  register-file read addresses, equal to instr_i[19:15] and instr_i[24:20], combinational.
REQ-007 rf_data_rs1_i, rf_data_rs2_i  input  BITSIZE each  register-file read data, which reflects registered state only, with no write-through.
REQ-008 wb_valid_i, wb_rd_i, wb_data_i  input  1 / 5 / BITSIZE  write-back result driven to the register file this cycle.
REQ-009 flush_i  input  1  discard the instruction held in the output register.
REQ-010 ex_valid_o / ex_ready_i  output / input  1 / 1  execute-side handshake.
REQ-011 ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  output  BITSIZE each  resolved operands and sign-extended immediate.
REQ-012 ex_rd_o, ex_opcode_o, ex_funct3_o, ex_funct7_o  output  5 / 7 / 3 / 7  decoded fields.

Function
REQ-013 Usage decode shall be fixed as follows: rs1 is used unless opcode is LUI, AUIPC or JAL; rs2 is used for OP, STORE and BRANCH; rd is written unless opcode is STORE or BRANCH, or rd is 0.
REQ-014 Operand resolution shall apply these rules in priority order: address 0 gives 0; if wb_valid_i and wb_rd_i equals the address, the value is wb_data_i (bypass); otherwise the value is rf_data.
REQ-015 Scoreboard: a 32-bit pending mask; bit 0 shall always read 0.
REQ-016 A scoreboard bit shall be set on an execute handshake (ex_valid_o and ex_ready_i) for the held instruction's rd when that instruction writes rd.
REQ-017 A scoreboard bit shall be cleared when wb_valid_i is high for wb_rd_i; if a set and a clear hit the same rd in one cycle, the set shall win.
REQ-018 A hazard exists when a used rs is pending and not cleared this cycle, or when it equals the rd of a valid, rd-writing instruction in the output register that is not issuing this cycle.
REQ-019 An rs that is issuing this cycle shall also count as a hazard, because it becomes pending.
REQ-020 instr_ready_o shall be high exactly when: no hazard, and (ex_valid_o is 0 or ex_ready_i is 1), and flush_i is 0, and the block is not in reset.
REQ-021 On accept (instr_valid_i and instr_ready_o), the output register shall load the resolved operands, immediate and fields, and ex_valid_o shall be 1 on the next cycle.
REQ-022 Latency shall be 1 cycle from accept to ex_valid_o.
REQ-023 If the output register drains with no accept, ex_valid_o shall go to 0.
REQ-024 While ex_valid_o is 1 and ex_ready_i is 0, all ex_* outputs shall hold stable.
REQ-025 Immediate generation: I-type, S-type, B-type (bit 0 = 0), U-type (low 12 bits = 0) and J-type (bit 0 = 0) shall all be sign-extended from instr_i[31]; other opcodes shall give 0.
REQ-026 flush_i shall take priority over everything else: ex_valid_o becomes 0 next cycle, no scoreboard set occurs, no accept occurs, and scoreboard clears still apply.
REQ-027 When ex_valid_o is 0, ex_* data outputs are don't-care but shall not be X after reset.

Reset
REQ-028 While rstn_i is 0, ex_valid_o and instr_ready_o shall be 0, the scoreboard shall be all zeros, and every ex_* output shall be 0, effective immediately.
REQ-029 Reset asserted mid-stall or mid-handshake shall drop the held instruction; the first accept shall occur no earlier than the first rising edge after rstn_i returns to 1.

Verification
REQ-030 Accept ADDI x5,x0,7 (0x00700293), ex_ready_i=1 -> next cycle ex_valid_o=1, ex_rd_o=5, ex_imm_o=7, ex_rs1_data_o=0; scoreboard bit 5 set after issue.
REQ-031 Issue x5 writer, then present ADD x6,x5,x5 with no write-back -> instr_ready_o=0 every cycle; assert wb_valid_i, wb_rd_i=5, wb_data_i=0x1234 -> accepted that cycle with both operands 0x1234 via bypass.
REQ-032 ex_ready_i=0 for 3 cycles with a valid held instruction -> ex_* outputs unchanged, instr_ready_o=0; ex_ready_i=1 -> issue, and the next accept occurs in the same cycle.
REQ-033 Held instruction writes x7 and flush_i=1 -> ex_valid_o=0 next cycle, scoreboard bit 7 not set, a later reader of x7 is not stalled.
REQ-034 Same cycle: issue writer of x9 while wb_valid_i clears x9 -> bit 9 remains set; BEQ immediate instr 0xFE000EE3 -> ex_imm_o=0xFFFFFFFC.
REQ-035 rstn_i pulsed low while scoreboard = 0x00000060 and ex_valid_o=1 -> immediately ex_valid_o=0 and scoreboard=0; a reader of x5/x6 is accepted right after release.
